pt_stage_sequencer: RTL and testbench

Per-sample sequencer for the Pan-Tompkins filter chain (bandpass, derivative, squaring, moving-window integrator). It accepts ADC sample strobes and registers the sample for stage 0. It then issues one-cycle enable pulses to each stage in chain order, one stage per cycle, so every stage sees a settled upstream value. It counts samples to flag filter warm-up, emits a result-valid strobe, and counts dropped (overrun) samples.

---
 rtl/pt_pkg.sv | 18 +
 rtl/pt_sat_counter.sv | 27 ++
 rtl/pt_stage_sequencer.sv | 136 +++++++++++++
 tb/tb_pt_stage_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pt_pkg.sv
// Shared definitions for the Pan-Tompkins filter chain: sequencer states
// and widths common to the sequencer and the filter stages.
package pt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEQ  = 2'd2,
    ST_EMIT = 2'd3
  } pt_state_e;

  // Sample width used by every stage of the chain.
  localparam int DATA_WIDTH = 11;

  // Width of the dropped-sample counter (saturates at 255).
  localparam int OVR_CNT_W  = 8;

endpackage

// File: rtl/pt_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module pt_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  // Count up on inc_i, stick at all-ones, clear has priority.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pt_stage_sequencer.sv
// Per-sample sequencer for the Pan-Tompkins chain. Latches an ADC sample,
// walks a one-hot enable through the stages one per cycle, then flags the
// result valid once the filters have warmed up. Dropped samples are counted.
module pt_stage_sequencer
  import pt_pkg::*;
#(
  parameter int DATA_WIDTH = pt_pkg::DATA_WIDTH,
  parameter int NUM_STAGES = 4,
  parameter int WARMUP     = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  run,
  input  logic                  s_strobe,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  clr_ovr,
  output logic [DATA_WIDTH-1:0] x_data,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  busy,
  output logic                  m_valid,
  output logic                  warm,
  output logic [CNT_WIDTH-1:0]  sample_cnt,
  output logic [OVR_CNT_W-1:0]  ovr_cnt
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_STAGES - 1);
  localparam logic [CNT_WIDTH:0] WARM_THR = (CNT_WIDTH + 1)'(WARMUP);

  pt_state_e             state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic                  warm_q, warm_d;
  logic                  cnt_inc, cnt_clr, ovr_inc;
  logic [CNT_WIDTH:0]    cnt_post;
  logic                  warm_hit;

  // Post-increment sample count (saturating) used for the warm-up compare.
  always_comb begin
    cnt_post = {1'b0, sample_cnt};
    if (sample_cnt != {CNT_WIDTH{1'b1}}) cnt_post = {1'b0, sample_cnt} + (CNT_WIDTH + 1)'(1);
    warm_hit = (cnt_post >= WARM_THR) || warm_q;
  end

  // State, stage index, latched sample and warm flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      warm_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      warm_q  <= warm_d;
    end
  end

  // Next-state logic; counter strobes are decoded here as well.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    warm_d  = warm_q;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    ovr_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Strobes are ignored here; a fresh run restarts warm-up.
        if (run) begin
          state_d = ST_WAIT;
          cnt_clr = 1'b1;
          warm_d  = 1'b0;
        end
      end
      ST_WAIT: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (s_strobe) begin
          x_d     = s_data;
          idx_d   = '0;
          state_d = ST_SEQ;
        end
      end
      ST_SEQ: begin
        // Abort leaves stages partially updated; no valid is produced.
        if (!run) begin
          state_d = ST_IDLE;
        end else begin
          ovr_inc = s_strobe;
          if (idx_q == IDX_LAST) state_d = ST_EMIT;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      ST_EMIT: begin
        // All stages have run: the sample counts and the result is out.
        cnt_inc = 1'b1;
        if (warm_hit) warm_d = 1'b1;
        if (!run) begin
          state_d = ST_IDLE;
        end else begin
          ovr_inc = s_strobe;
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  pt_sat_counter #(.WIDTH(CNT_WIDTH)) u_sample_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc_i (cnt_inc),
    .clr_i (cnt_clr),
    .cnt_o (sample_cnt)
  );

  pt_sat_counter #(.WIDTH(OVR_CNT_W)) u_ovr_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc_i (ovr_inc),
    .clr_i (clr_ovr),
    .cnt_o (ovr_cnt)
  );

  // Outputs decode straight from registered state so the pulses are clean.
  assign stage_en = (state_q == ST_SEQ) ? (NUM_STAGES'(1) << idx_q) : '0;
  assign busy     = (state_q == ST_SEQ) || (state_q == ST_EMIT);
  assign m_valid  = (state_q == ST_EMIT) && warm_hit;
  assign warm     = warm_q;
  assign x_data   = x_q;

endmodule

// File: tb/tb_pt_stage_sequencer.sv
// Bench for pt_stage_sequencer: directed scenarios plus random traffic,
// checked against a sample-level reference model and a result scoreboard.
module tb_pt_stage_sequencer;

  localparam int DW = 11;
  localparam int NS = 4;
  localparam int WU = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rstn_r = 1'b0, run_r = 1'b0, st_r = 1'b0, clr_r = 1'b0;
  logic [DW-1:0] d_r = '0;
  logic [DW-1:0] x_data;
  logic [NS-1:0] stage_en;
  logic          busy, m_valid, warm;
  logic [CW-1:0] sample_cnt;
  logic [7:0]    ovr_cnt;

  pt_stage_sequencer #(.DATA_WIDTH(DW), .NUM_STAGES(NS), .WARMUP(WU), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn_r), .run(run_r), .s_strobe(st_r), .s_data(d_r),
    .clr_ovr(clr_r), .x_data(x_data), .stage_en(stage_en), .busy(busy),
    .m_valid(m_valid), .warm(warm), .sample_cnt(sample_cnt), .ovr_cnt(ovr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] x; bit mv; } res_t;
  res_t sb[$];

  int n_chk = 0, n_fail = 0;
  bit mon_en = 1'b0;

  // Reference model: whole-sample view of the sequencer.
  int      edge_n = 0, acc = 0;
  bit      pend = 0, active = 0;
  logic [DW-1:0] m_x = '0;
  int      m_cnt = 0, m_ovr = 0;
  bit      m_warm = 0, m_busy = 0;
  logic [NS-1:0] m_en = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_n, act, exp);
    end
  endtask

  // Called at each rising edge with the inputs the DUT sampled there.
  task automatic model_step();
    int ph;
    bit busy_prev, emit_prev, seq_prev;
    res_t r;
    ph        = edge_n - 1 - acc;
    busy_prev = pend && ph >= 0 && ph <= NS;
    emit_prev = pend && ph == NS;
    seq_prev  = pend && ph >= 0 && ph < NS;
    if (!rstn_r) begin
      if (seq_prev) void'(sb.pop_back());
      pend = 0; active = 0; m_x = '0; m_cnt = 0; m_warm = 0; m_ovr = 0;
    end else begin
      if (emit_prev) begin
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        if (m_cnt >= WU) m_warm = 1;
        pend = 0;
      end
      if (!active) begin
        if (run_r) begin active = 1; m_cnt = 0; m_warm = 0; end
      end else if (!run_r) begin
        active = 0;
        if (seq_prev) begin void'(sb.pop_back()); pend = 0; end
      end else if (st_r) begin
        if (busy_prev) begin
          if (m_ovr < 255) m_ovr++;
        end else begin
          pend = 1; acc = edge_n; m_x = d_r;
          r.x  = d_r;
          r.mv = m_warm || ((m_cnt < (1 << CW) - 1 ? m_cnt + 1 : m_cnt) >= WU);
          sb.push_back(r);
        end
      end
      if (clr_r) m_ovr = 0;
    end
    ph     = edge_n - acc;
    m_en   = (pend && ph < NS) ? NS'(1) << ph : '0;
    m_busy = pend && ph <= NS;
    edge_n++;
  endtask

  task automatic step(input bit st = 0, input logic [DW-1:0] d = '0, input bit cl = 0);
    st_r = st; d_r = d; clr_r = cl;
    @(posedge clk);
    model_step();
    #1;
    st_r = 0; clr_r = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: state checks every cycle, scoreboard pop whenever a result is presented.
  always @(negedge clk) begin
    res_t r;
    if (mon_en) begin
      chk("stage_en", 32'(stage_en), 32'(m_en));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("x_data", 32'(x_data), 32'(m_x));
      chk("sample_cnt", 32'(sample_cnt), 32'(m_cnt));
      chk("warm", 32'(warm), 32'(m_warm));
      chk("ovr_cnt", 32'(ovr_cnt), 32'(m_ovr));
      if (busy && stage_en == '0) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL result_unexpected at edge %0d: got emit expected none", edge_n);
        end else begin
          r = sb.pop_front();
          chk("m_valid", 32'(m_valid), 32'(r.mv));
          chk("emit_x", 32'(x_data), 32'(r.x));
        end
      end else begin
        chk("m_valid_idle", 32'(m_valid), 32'd0);
      end
    end
  end

  initial begin
    int hold;
    rstn_r = 0; run_r = 0;
    step(); mon_en = 1; step();
    rstn_r = 1; idle(2);

    // Single sample walks through all stages.
    run_r = 1; idle(2);
    step(1, 11'h155); idle(8);

    // Warm-up from a fresh run: third and fourth samples are valid.
    run_r = 0; step(); run_r = 1; step();
    for (int i = 0; i < 4; i++) begin step(1, DW'($urandom)); idle(5); end

    // Overrun during SEQ, then saturation, then clear racing a drop.
    step(1, 11'h2aa); step(); step(1, 11'h011); idle(6);
    for (int i = 0; i < 60; i++)
      for (int j = 0; j < 6; j++) step(1, DW'($urandom));
    idle(6);
    step(1, 11'h0f0); step(); step(1, 11'h00f, 1); idle(6);

    // Abort mid-SEQ, then restart.
    step(1, 11'h123); step(); run_r = 0; step(1, 11'h321); idle(3);
    run_r = 1; idle(2);

    // Reset during EMIT, strobes in IDLE ignored.
    step(1, 11'h7ff); idle(3); step();
    rstn_r = 0; step();
    rstn_r = 1; run_r = 0; step(1, 11'h555); step(1, 11'h666);
    run_r = 1; step(1, 11'h777); idle(2);

    // Minimum spacing accepted, one cycle shorter dropped.
    step(1, 11'h101); idle(NS + 1); step(1, 11'h202); idle(NS);
    step(1, 11'h303); idle(8);

    // Random traffic with run drops, clears and occasional reset.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold > 0) begin hold--; if (hold == 0) run_r = 1; end
      else if ($urandom_range(63) == 0) begin run_r = 0; hold = $urandom_range(4, 1); end
      rstn_r = ($urandom_range(499) != 0);
      step($urandom_range(2) == 0, DW'($urandom), $urandom_range(49) == 0);
    end
    rstn_r = 1; run_r = 1; idle(10);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
